prog_loader: RTL and testbench

- Upstream boot stage for the 16-bit processor core. Receives a program image as a stream of 16-bit words over a valid/ready handshake.
- Writes each word into the 512-entry instruction memory through its write port.
- Checks a trailing checksum. Holds the core in reset until a load completes cleanly, then releases it so the PC starts fetching at address 0.

---
 rtl/prog_loader.sv | 167 ++++++++++++++++
 tb/tb_prog_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-stage program loader. Accepts a header word (program
//                length), streams that many instruction words into the
//                instruction memory write port, verifies a trailing 16-bit
//                additive checksum and releases the core from reset only
//                after a clean load.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int AW    = 9,
    parameter int DW    = 16,
    parameter int DEPTH = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          im_wen,
    output logic [AW-1:0] im_addr,
    output logic [DW-1:0] im_wdata,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Word counter and latched length need one extra bit so a full
    // DEPTH-word program (len == 2**AW) is representable.
    localparam int CW = AW + 1;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HDR  = 3'd1;
    localparam logic [2:0] c_ST_LOAD = 3'd2;
    localparam logic [2:0] c_ST_CHK  = 3'd3;
    localparam logic [2:0] c_ST_RUN  = 3'd4;
    localparam logic [2:0] c_ST_ERR  = 3'd5;

    localparam logic [DW-1:0] c_DEPTH_W = DW'(DEPTH);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_in_ready;
    logic          r_im_wen;
    logic [AW-1:0] r_im_addr;
    logic [DW-1:0] r_im_wdata;
    logic          r_core_rst;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_len;
    logic [DW-1:0] r_sum;

    logic          w_accept;
    logic          w_len_bad;
    logic          w_restart;
    logic          w_nxt_active;
    logic [CW-1:0] w_count_inc;

    // A word only moves when the loader advertised ready in this cycle.
    assign w_accept     = in_valid && r_in_ready;
    assign w_len_bad    = (in_data == '0) || (in_data > c_DEPTH_W);
    assign w_count_inc  = r_count + CW'(1);
    // start is honoured only outside an active load.
    assign w_restart    = start && ((r_state == c_ST_IDLE) ||
                                    (r_state == c_ST_RUN)  ||
                                    (r_state == c_ST_ERR));
    assign w_nxt_active = (w_state_nxt == c_ST_HDR)  ||
                          (w_state_nxt == c_ST_LOAD) ||
                          (w_state_nxt == c_ST_CHK);

    // Next-state decision for the load sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_RUN, c_ST_ERR: begin
                if (start) begin
                    w_state_nxt = c_ST_HDR;
                end
            end
            c_ST_HDR: begin
                if (w_accept) begin
                    w_state_nxt = w_len_bad ? c_ST_ERR : c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (w_accept && (w_count_inc == r_len)) begin
                    w_state_nxt = c_ST_CHK;
                end
            end
            c_ST_CHK: begin
                if (w_accept) begin
                    w_state_nxt = (in_data == r_sum) ? c_ST_RUN : c_ST_ERR;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register and status outputs, registered from the next state so
    // every status flag lines up with the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_nxt_active;
            r_busy     <= w_nxt_active;
            r_done     <= (w_state_nxt == c_ST_RUN);
            r_err      <= (w_state_nxt == c_ST_ERR);
            r_core_rst <= (w_state_nxt != c_ST_RUN);
        end
    end

    // Load datapath: length latch, word counter, running checksum and the
    // one-cycle registered memory write for every accepted program word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_len      <= '0;
            r_sum      <= '0;
            r_im_wen   <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
        end else begin
            r_im_wen <= 1'b0;
            if (w_restart) begin
                r_count <= '0;
                r_sum   <= '0;
            end
            if (w_accept && (r_state == c_ST_HDR) && !w_len_bad) begin
                r_len <= in_data[CW-1:0];
            end
            // The count < len guard keeps the address from ever stepping past
            // the last programmed word, even if the length latch were stale.
            if (w_accept && (r_state == c_ST_LOAD) && (r_count < r_len)) begin
                r_im_wen   <= 1'b1;
                r_im_addr  <= r_count[AW-1:0];
                r_im_wdata <= in_data;
                r_sum      <= r_sum + in_data;
                r_count    <= w_count_inc;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign im_wen   = r_im_wen;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign core_rst = r_core_rst;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader: directed vector table,
//                hand-written corner sequences and randomized loads checked
//                against a stream-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          im_wen;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;

    prog_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_wen   (im_wen),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int          wr_addr_q[$];
    int          wr_data_q[$];
    int          wr_cyc_q[$];
    int          acc_cyc_q[$];
    logic [15:0] stream_q[$];

    typedef struct {
        string       name;
        int          n;
        logic [15:0] w0, w1, w2, w3, w4;
        int          stall;
        bit          exp_done;
        bit          exp_err;
        int          exp_nwr;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observe accepts and writes; check status relationships every cycle.
    always @(negedge clk) begin
        if (in_valid && in_ready) acc_cyc_q.push_back(cyc);
        if (im_wen) begin
            wr_addr_q.push_back(int'(im_addr));
            wr_data_q.push_back(int'(im_wdata));
            wr_cyc_q.push_back(cyc);
        end
        check("inv_busy_eq_ready", int'(busy), int'(in_ready));
        check("inv_done_err_excl", int'(done && err), 0);
        check("inv_core_rst_vs_done", int'(core_rst), int'(!done));
    end

    task automatic check_reset_vals(input string name);
        check({name, "_in_ready"}, int'(in_ready), 0);
        check({name, "_im_wen"},   int'(im_wen),   0);
        check({name, "_im_addr"},  int'(im_addr),  0);
        check({name, "_im_wdata"}, int'(im_wdata), 0);
        check({name, "_core_rst"}, int'(core_rst), 1);
        check({name, "_busy"},     int'(busy),     0);
        check({name, "_done"},     int'(done),     0);
        check({name, "_err"},      int'(err),      0);
    endtask

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one word and hold it until the loader takes it (bounded).
    task automatic push_word(input logic [15:0] w, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    // Run the load in stream_q and compare against the reference model:
    // header 0 or > DEPTH fails immediately; otherwise the next len words
    // land at addresses 0..len-1 and the following word must equal their
    // sum mod 2^16.
    task automatic do_load(input int stall, input string name, output bit exp_done);
        int hdr;
        int nw;
        int sum;
        bit good;
        bit ok;
        int exp_wr[$];
        hdr  = int'(stream_q[0]);
        good = (hdr != 0) && (hdr <= DEPTH);
        sum  = 0;
        if (good) begin
            for (int i = 1; i <= hdr; i++) begin
                exp_wr.push_back(int'(stream_q[i]));
                sum = (sum + int'(stream_q[i])) % 65536;
            end
        end
        nw       = good ? hdr + 2 : 1;
        exp_done = good && (int'(stream_q[hdr + 1]) == sum);

        clear_obs();
        pulse_start();
        for (int i = 0; i < nw; i++) begin
            push_word(stream_q[i], ok);
            if (!ok) begin
                check({name, "_accept_timeout"}, 0, 1);
                break;
            end
            repeat (stall) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        check({name, "_n_accepts"}, acc_cyc_q.size(), nw);
        check({name, "_n_writes"}, wr_addr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_wr%0d_addr", name, i), wr_addr_q[i], i);
            check($sformatf("%s_wr%0d_data", name, i), wr_data_q[i], exp_wr[i]);
            if (acc_cyc_q.size() > i + 1)
                check($sformatf("%s_wr%0d_latency", name, i), wr_cyc_q[i], acc_cyc_q[i + 1] + 1);
        end
        check({name, "_done"},     int'(done),     int'(exp_done));
        check({name, "_err"},      int'(err),      int'(!exp_done));
        check({name, "_core_rst"}, int'(core_rst), int'(!exp_done));
        check({name, "_in_ready"}, int'(in_ready), 0);
        check({name, "_busy"},     int'(busy),     0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ed;
        bit          ok;
        int          hdr;
        int          sum;
        int          r;
        logic [15:0] w;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #3;
        check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_reset_idle");

        // Directed table.
        tbl[0] = '{"clean",   5, 16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h6666, 0, 1'b1, 1'b0, 3};
        tbl[1] = '{"badchk",  5, 16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h6667, 0, 1'b0, 1'b1, 3};
        tbl[2] = '{"hdr0",    1, 16'd0, 16'h0,    16'h0,    16'h0,    16'h0,    0, 1'b0, 1'b1, 0};
        tbl[3] = '{"hdr513",  1, 16'd513, 16'h0,  16'h0,    16'h0,    16'h0,    0, 1'b0, 1'b1, 0};
        tbl[4] = '{"stallwrap", 4, 16'd2, 16'hFFFF, 16'h0002, 16'h0001, 16'h0, 3, 1'b1, 1'b0, 2};

        for (int v = 0; v < 5; v++) begin
            stream_q.delete();
            stream_q.push_back(tbl[v].w0);
            if (tbl[v].n > 1) stream_q.push_back(tbl[v].w1);
            if (tbl[v].n > 2) stream_q.push_back(tbl[v].w2);
            if (tbl[v].n > 3) stream_q.push_back(tbl[v].w3);
            if (tbl[v].n > 4) stream_q.push_back(tbl[v].w4);
            do_load(tbl[v].stall, tbl[v].name, ed);
            check({tbl[v].name, "_tbl_done"}, int'(done), int'(tbl[v].exp_done));
            check({tbl[v].name, "_tbl_err"},  int'(err),  int'(tbl[v].exp_err));
            check({tbl[v].name, "_tbl_nwr"},  wr_addr_q.size(), tbl[v].exp_nwr);
        end

        // Full-size program: word i is i, checksum 0xFF00.
        stream_q.delete();
        stream_q.push_back(16'd512);
        for (int i = 0; i < 512; i++) stream_q.push_back(16'(i));
        stream_q.push_back(16'hFF00);
        do_load(0, "full", ed);
        check("full_last_addr", (wr_addr_q.size() > 0) ? wr_addr_q[$] : -1, 511);
        check("full_last_data", (wr_data_q.size() > 0) ? wr_data_q[$] : -1, 16'h01FF);
        check("full_done", int'(done), 1);

        // Reset in the middle of a 10-word load.
        clear_obs();
        pulse_start();
        push_word(16'd10, ok);
        for (int i = 0; i < 5; i++) push_word(16'h0100 + 16'(i), ok);
        check("midrst_writes_before", wr_addr_q.size() + int'(im_wen), 5);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        clear_obs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_writes", wr_addr_q.size(), 0);
        check_reset_vals("midrst_after");

        // Reload after reset, with start pulses during the load ignored.
        clear_obs();
        pulse_start();
        push_word(16'd1, ok);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_word(16'hABCD, ok);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_word(16'hABCD, ok);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reload_n_writes", wr_addr_q.size(), 1);
        check("reload_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, 0);
        check("reload_data", (wr_data_q.size() > 0) ? wr_data_q[0] : -1, 16'hABCD);
        check("reload_done", int'(done), 1);
        check("reload_core_rst", int'(core_rst), 0);

        // Randomized loads.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      hdr = 0;
            else if (r == 1) hdr = $urandom_range(513, 65535);
            else             hdr = $urandom_range(1, 24);
            stream_q.delete();
            stream_q.push_back(16'(hdr));
            if (hdr != 0 && hdr <= DEPTH) begin
                sum = 0;
                for (int i = 0; i < hdr; i++) begin
                    w = 16'($urandom);
                    stream_q.push_back(w);
                    sum = (sum + int'(w)) % 65536;
                end
                if ($urandom_range(0, 3) != 0) stream_q.push_back(16'(sum));
                else stream_q.push_back(16'(sum) ^ 16'($urandom_range(1, 65535)));
            end
            do_load($urandom_range(0, 2), $sformatf("rand%0d", k), ed);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
